// File: rtl/div8by4_seq.sv
// div8by4_seq: iterative restoring divider, one quotient bit per clock.
// Divides a product-width dividend by an operand-width divisor, which makes it
// the inverse datapath of the 4x4 multipliers (P / B must give back A, rem 0).
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | waiting for start; also holds the one-cycle divide-by-zero wait
// RUN   | shifting/subtracting, one quotient bit per edge
// DONE  | results valid, done pulses; start is accepted here (back-to-back)
module div8by4_seq #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  logic [DIVISOR_W:0]    r_q;
  logic [DIVIDEND_W-1:0] q_q;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [CNT_W-1:0]      cnt;
  // A zero divisor spends one idle cycle before reporting, so done lands one
  // edge after acceptance without ever raising busy.
  logic                  dz_pend;

  logic [DIVISOR_W:0]    r_shift;
  logic [DIVISOR_W:0]    r_trial;
  logic                  trial_ok;
  logic [DIVISOR_W:0]    r_next;
  logic [DIVIDEND_W-1:0] q_next;

  // One restoring step: shift {R,Q} left, trial-subtract the divisor, keep or restore.
  always_comb begin
    r_shift  = {r_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};
    r_trial  = r_shift - {1'b0, divisor_q};
    trial_ok = (r_shift >= {1'b0, divisor_q});
    r_next   = trial_ok ? r_trial : r_shift;
    q_next   = {q_q[DIVIDEND_W-2:0], trial_ok};
  end

  // Control FSM, iteration registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      cnt         <= '0;
      dz_pend     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (dz_pend) begin
            dz_pend     <= 1'b0;
            state       <= S_DONE;
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
          end else if (start) begin
            divisor_q <= divisor;
            r_q       <= '0;
            q_q       <= dividend;
            cnt       <= '0;
            if (divisor == '0) begin
              dz_pend <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_q <= r_next;
          q_q <= q_next;
          cnt <= cnt + 1'b1;
          // Terminal count stops the run after exactly DIVIDEND_W steps.
          if (cnt == LAST_ITER) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div8by4_seq.sv
// tb_div8by4_seq: directed and random checks of div8by4_seq against a
// transaction-level model (plain division, acceptance edge + fixed latency).
module tb_div8by4_seq;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;

  int errors = 0;
  int checks = 0;

  div8by4_seq #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Model state: what every output must be after the most recent edge.
  logic          m_valid = 1'b0;
  logic          m_busy, m_done, m_dz;
  logic [DW-1:0] m_q;
  logic [VW-1:0] m_r;
  logic          pend = 1'b0;
  int            cyc = 0;
  int            due = 0;
  logic [DW-1:0] p_q;
  logic [VW-1:0] p_r;
  logic          p_dz;

  // Model: an accepted request completes a fixed number of edges later with
  // floor/mod results; nothing else is accepted while one is outstanding.
  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_busy = 1'b0; m_q = '0; m_r = '0; m_dz = 1'b0;
      pend = 1'b0;
    end else if (pend) begin
      if (cyc == due) begin
        pend = 1'b0;
        m_busy = 1'b0; m_done = 1'b1;
        m_q = p_q; m_r = p_r; m_dz = p_dz;
      end
    end else if (start) begin
      pend = 1'b1;
      if (divisor == 0) begin
        due = cyc + 1;
        p_q = 8'hFF; p_r = '0; p_dz = 1'b1;
      end else begin
        due = cyc + DW;
        p_q = DW'(int'(dividend) / int'(divisor));
        p_r = VW'(int'(dividend) % int'(divisor));
        p_dz = 1'b0;
        m_busy = 1'b1;
      end
    end
  end

  // Per-cycle compare of all outputs against the model, away from the edge.
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if ({busy, done, quotient, remainder, div_by_zero} !==
          {m_busy, m_done, m_q, m_r, m_dz}) begin
        errors++;
        $display("FAIL cycle %0d outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want busy=%b done=%b q=%0d r=%0d dz=%b",
                 cyc, busy, done, quotient, remainder, div_by_zero,
                 m_busy, m_done, m_q, m_r, m_dz);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Issue one request (called at posedge+#1), wait for done, check literals.
  task automatic op(input logic [DW-1:0] a, input logic [VW-1:0] b,
                    input int eq, input int er, input int edz, input int elat);
    int lat;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("quotient", int'(quotient), eq);
    chk("remainder", int'(remainder), er);
    chk("div_by_zero", int'(div_by_zero), edz);
  endtask

  initial begin
    int lat;
    int seen_done;
    logic [DW-1:0] ra;
    logic [VW-1:0] rb;

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset quotient", int'(quotient), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, the later ones launched in the DONE cycle of the previous.
    op(8'd225, 4'd15, 15, 0, 0, 8);
    op(8'd200, 4'd7, 28, 4, 0, 8);
    op(8'd3, 4'd9, 0, 3, 0, 8);
    op(8'd0, 4'd5, 0, 0, 0, 8);
    op(8'd77, 4'd1, 77, 0, 0, 8);
    op(8'd77, 4'd0, 255, 0, 1, 1);
    op(8'd255, 4'd1, 255, 0, 0, 8);
    op(8'd255, 4'd15, 17, 0, 0, 8);
    op(8'd254, 4'd15, 16, 14, 0, 8);

    // Start during RUN is ignored; the first result stands.
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      if (lat == 3) begin
        start = 1'b1; dividend = 8'd13; divisor = 4'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk("ignored start latency", lat, 8);
    chk("ignored start quotient", int'(quotient), 28);
    chk("ignored start remainder", int'(remainder), 4);
    @(posedge clk); #1;

    // Reset mid-operation abandons the division.
    start = 1'b1; dividend = 8'd100; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midop reset busy", int'(busy), 0);
    chk("midop reset quotient", int'(quotient), 0);
    chk("midop reset remainder", int'(remainder), 0);
    seen_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    chk("abandoned op done count", seen_done, 0);
    op(8'd100, 4'd3, 33, 1, 0, 8);

    // Multiplier inverse: every A*B with B != 0 gives back A with remainder 0.
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        op(DW'(a * b), VW'(b), a, 0, 0, 8);
      end
    end

    // Random operand pairs, divisor 0 included.
    for (int i = 0; i < 2000; i++) begin
      ra = DW'($urandom_range(255, 0));
      rb = VW'($urandom_range(15, 0));
      if (rb == 0)
        op(ra, rb, 255, 0, 1, 1);
      else
        op(ra, rb, int'(ra) / int'(rb), int'(ra) % int'(rb), 0, 8);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
